// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and defaults for the SDRAM channel arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_CLIENT = 2'd0,
    OP_REF0   = 2'd1,
    OP_REF1   = 2'd2
  } op_t;

  localparam int DEF_NUM_CLIENTS    = 4;
  localparam int DEF_ADDR_W         = 25;
  localparam int DEF_REFRESH_CYCLES = 600;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority request selector
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int               j;
      logic [IDX_W-1:0] j_idx;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      j_idx = j[IDX_W-1:0];
      if (req[j_idx]) begin
        idx   = j_idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_ch_arbiter.sv
// rtl/sdram_ch_arbiter.sv - round-robin SDRAM channel sharing with refresh watchdog
module sdram_ch_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = DEF_NUM_CLIENTS,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        cl_req,
  input  logic [NUM_CLIENTS-1:0]        cl_we,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*8-1:0]      cl_din,
  output logic [NUM_CLIENTS-1:0]        cl_ack,
  output logic [7:0]                    cl_dout,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic                          mem_rd,
  output logic                          mem_wr,
  output logic [7:0]                    mem_din,
  input  logic [7:0]                    mem_dout,
  input  logic                          mem_busy,
  output logic                          refresh_forced
);

  localparam int IDX_W = $clog2(NUM_CLIENTS);
  localparam int CNT_W = $clog2(REFRESH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CLIENTS - 1);

  state_t              state, state_nxt;
  op_t                 op_q;
  logic                we_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [IDX_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]    ref_cnt;
  logic                last_rd_valid;
  logic [ADDR_W-2:0]   last_rd_word;

  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [ADDR_W-1:0]   sel_addr;
  logic [7:0]          sel_din;
  logic                sel_we;
  logic                ref_due;
  logic                grant_ref;
  logic                grant_cl;
  logic                grant_rd_hit;
  logic                done_now;
  logic [ADDR_W-1:0]   ref_addr;
  op_t                 ref_op;

  rr_arbiter #(
    .N     (NUM_CLIENTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req   (cl_req),
    .ptr   (rr_ptr),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_we   = 1'b0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr = cl_addr[i*ADDR_W +: ADDR_W];
        sel_din  = cl_din[i*8 +: 8];
        sel_we   = cl_we[i];
      end
    end
  end

  // Without a tracked read, a priming read of 0 precedes the refresh read of 0.
  assign ref_due   = (ref_cnt == CNT_MAX);
  assign ref_addr  = last_rd_valid ? {last_rd_word, 1'b0} : '0;
  assign ref_op    = last_rd_valid ? OP_REF1 : OP_REF0;
  assign grant_ref = (state == IDLE) && !mem_busy && ref_due;
  assign grant_cl  = (state == IDLE) && !mem_busy && !ref_due && arb_valid;
  assign done_now  = (state == WAIT) && !mem_busy;

  assign grant_rd_hit = last_rd_valid &&
                        (grant_ref ||
                         (grant_cl && !sel_we && (sel_addr[ADDR_W-1:1] == last_rd_word)));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ref || grant_cl) state_nxt = ISSUE;
      ISSUE:   if (mem_busy)              state_nxt = WAIT;
      WAIT:    if (!mem_busy)             state_nxt = DONE;
      DONE:                               state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    if (state == ISSUE) begin
      mem_rd = !we_q;
      mem_wr = we_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr       <= '0;
      mem_din        <= '0;
      we_q           <= 1'b0;
      op_q           <= OP_CLIENT;
      gnt_q          <= '0;
      rr_ptr         <= '0;
      ref_cnt        <= '0;
      last_rd_valid  <= 1'b0;
      last_rd_word   <= '0;
      cl_ack         <= '0;
      cl_dout        <= '0;
      refresh_forced <= 1'b0;
    end else begin
      refresh_forced <= grant_ref;
      cl_ack         <= '0;

      if (grant_rd_hit)   ref_cnt <= '0;
      else if (!ref_due)  ref_cnt <= ref_cnt + CNT_W'(1);

      if (grant_ref) begin
        mem_addr <= ref_addr;
        we_q     <= 1'b0;
        op_q     <= ref_op;
      end else if (grant_cl) begin
        mem_addr <= sel_addr;
        mem_din  <= sel_din;
        we_q     <= sel_we;
        op_q     <= OP_CLIENT;
        gnt_q    <= arb_idx;
        rr_ptr   <= (arb_idx == IDX_LAST) ? '0 : arb_idx + IDX_W'(1);
      end

      // Ack and read data are captured together so cl_dout is valid during the ack cycle.
      if (done_now) begin
        if (we_q) begin
          last_rd_valid <= 1'b0;
        end else begin
          last_rd_valid <= 1'b1;
          last_rd_word  <= mem_addr[ADDR_W-1:1];
        end
        if (op_q == OP_CLIENT) begin
          cl_ack[gnt_q] <= 1'b1;
          if (!we_q) cl_dout <= mem_dout;
        end
      end
    end
  end

endmodule
